// File: rtl/scanner_pkg.sv
// Shared definitions for the scanner lot sequencer: state encoding, defaults,
// handler latency reference values and the command decode helper.
package scanner_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE      = 4'd0;
    localparam logic [STATE_W-1:0] ST_RL_LOAD   = 4'd1;
    localparam logic [STATE_W-1:0] ST_WL_LOAD   = 4'd2;
    localparam logic [STATE_W-1:0] ST_EXPOSE    = 4'd3;
    localparam logic [STATE_W-1:0] ST_WL_UNLOAD = 4'd4;
    localparam logic [STATE_W-1:0] ST_RL_UNLOAD = 4'd5;
    localparam logic [STATE_W-1:0] ST_GAP       = 4'd6;
    localparam logic [STATE_W-1:0] ST_DONE      = 4'd7;
    localparam logic [STATE_W-1:0] ST_FAULT     = 4'd8;

    localparam int DEF_EXPOSE_CYCLES  = 8;
    localparam int DEF_TIMEOUT_CYCLES = 16;
    localparam int DEF_LOT_W          = 4;

    // Edges from command rise until the handler raises its ready.
    localparam int WL_LATENCY = 5;
    localparam int RL_LATENCY = 4;

    // One bit per handler command; at most one is ever set.
    typedef struct packed {
        logic rl_load;
        logic wl_load;
        logic wl_unload;
        logic rl_unload;
    } cmd_t;

    // Moore decode of the command lines from a state code.
    function automatic cmd_t decode_cmd(input logic [STATE_W-1:0] st);
        cmd_t c;
        c = '0;
        case (st)
            ST_RL_LOAD:   c.rl_load   = 1'b1;
            ST_WL_LOAD:   c.wl_load   = 1'b1;
            ST_WL_UNLOAD: c.wl_unload = 1'b1;
            ST_RL_UNLOAD: c.rl_unload = 1'b1;
            default:      c           = '0;
        endcase
        return c;
    endfunction

    // True for the states that hold a command toward the handler.
    function automatic logic is_cmd_state(input logic [STATE_W-1:0] st);
        return (st == ST_RL_LOAD) || (st == ST_WL_LOAD) ||
               (st == ST_WL_UNLOAD) || (st == ST_RL_UNLOAD);
    endfunction

endpackage

// File: rtl/scanner_sequencer_fsm_if.sv
// Handler-side command/ready bundle between the sequencer and the scanner
// handler (wafer loader and reticle loader).
interface scanner_sequencer_fsm_if;

    logic cmd_wl_load;
    logic cmd_wl_unload;
    logic cmd_rl_load;
    logic cmd_rl_unload;
    logic wl_ready;
    logic rl_ready;

    // Sequencer side: drives commands, receives readies.
    modport master (
        output cmd_wl_load,
        output cmd_wl_unload,
        output cmd_rl_load,
        output cmd_rl_unload,
        input  wl_ready,
        input  rl_ready
    );

    // Handler side: receives commands, drives readies.
    modport slave (
        input  cmd_wl_load,
        input  cmd_wl_unload,
        input  cmd_rl_load,
        input  cmd_rl_unload,
        output wl_ready,
        output rl_ready
    );

endinterface

// File: rtl/scanner_cmd_watchdog.sv
// Command watchdog: counts cycles a command has been held and flags a timeout
// when the held count reaches TIMEOUT_CYCLES without the matching ready.
module scanner_cmd_watchdog
    import scanner_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  logic ready,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // cnt holds the number of completed cycles; the current cycle is cnt+1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count held cycles; saturate at the last value so the counter never wraps.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with <= so every flop samples the
        // pre-edge value of the others, independent of statement order.
        if (reset || clear) begin
            cnt <= '0;
        end else if (run && (cnt != CNT_LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A ready in the expiring cycle suppresses the timeout.
    assign timeout = run && !ready && (cnt == CNT_LAST);

endmodule

// File: rtl/scanner_sequencer_fsm.sv
// Lot-level scanner sequencer: reticle load, lot_size x (wafer load, exposure,
// wafer unload), reticle unload. Commands are held as levels until the
// matching ready, separated by a one-cycle gap. All outputs are registered.
module scanner_sequencer_fsm
    import scanner_pkg::*;
#(
    parameter int EXPOSE_CYCLES  = DEF_EXPOSE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int LOT_W          = DEF_LOT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LOT_W-1:0]      lot_size,
    scanner_sequencer_fsm_if.master hif,
    output logic                  expose_active,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [LOT_W-1:0]      wafer_count
);

    localparam int EXP_W = $clog2(EXPOSE_CYCLES + 1);
    localparam logic [EXP_W-1:0] EXP_LAST = EXP_W'(EXPOSE_CYCLES - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [STATE_W-1:0] gap_from;     // command state that led into GAP
    logic [LOT_W-1:0]   lot_q;
    logic [EXP_W-1:0]   exp_cnt;
    logic               cmd_ready;
    logic               in_cmd;
    logic               abort_ok;
    logic               timeout;
    cmd_t               next_cmd;

    assign in_cmd   = is_cmd_state(state);
    assign next_cmd = decode_cmd(next_state);

    // Abort only acts while a lot is in progress (not IDLE, DONE or FAULT).
    assign abort_ok = abort && (state != ST_IDLE) && (state != ST_DONE) &&
                      (state != ST_FAULT);

    // Qualify ready only in the state commanding that loader.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        cmd_ready = 1'b0;
        case (state)
            ST_RL_LOAD, ST_RL_UNLOAD: cmd_ready = hif.rl_ready;
            ST_WL_LOAD, ST_WL_UNLOAD: cmd_ready = hif.wl_ready;
            default:                  cmd_ready = 1'b0;
        endcase
    end

    scanner_cmd_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_cmd),
        .run    (in_cmd),
        .ready  (cmd_ready),
        .timeout(timeout)
    );

    // Next-state decode; abort beats ready, ready beats timeout.
    always_comb begin
        next_state = state;
        if (abort_ok) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && (lot_size != '0)) next_state = ST_RL_LOAD;
                end
                ST_RL_LOAD, ST_WL_LOAD, ST_WL_UNLOAD, ST_RL_UNLOAD: begin
                    if (cmd_ready)    next_state = ST_GAP;
                    else if (timeout) next_state = ST_FAULT;
                end
                ST_EXPOSE: begin
                    if (exp_cnt == EXP_LAST) next_state = ST_WL_UNLOAD;
                end
                ST_GAP: begin
                    case (gap_from)
                        ST_RL_LOAD:   next_state = ST_WL_LOAD;
                        ST_WL_LOAD:   next_state = ST_EXPOSE;
                        ST_WL_UNLOAD: next_state = (wafer_count < lot_q) ?
                                                   ST_WL_LOAD : ST_RL_UNLOAD;
                        default:      next_state = ST_DONE;
                    endcase
                end
                ST_DONE:  next_state = ST_IDLE;
                ST_FAULT: next_state = ST_FAULT;
                default:  next_state = ST_IDLE;
            endcase
        end
    end

    // State, lot bookkeeping and the exposure timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            gap_from    <= ST_IDLE;
            lot_q       <= '0;
            wafer_count <= '0;
            exp_cnt     <= '0;
        end else begin
            state <= next_state;
            if (in_cmd) begin
                gap_from <= state;
            end
            if ((state == ST_IDLE) && (next_state == ST_RL_LOAD)) begin
                lot_q       <= lot_size;
                wafer_count <= '0;
            end else if ((state == ST_WL_UNLOAD) && (next_state == ST_GAP)) begin
                wafer_count <= wafer_count + 1'b1;
            end
            if (state == ST_EXPOSE) begin
                exp_cnt <= exp_cnt + 1'b1;
            end else begin
                exp_cnt <= '0;
            end
        end
    end

    // Registered Moore outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            hif.cmd_rl_load   <= 1'b0;
            hif.cmd_wl_load   <= 1'b0;
            hif.cmd_wl_unload <= 1'b0;
            hif.cmd_rl_unload <= 1'b0;
            expose_active     <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            fault             <= 1'b0;
        end else begin
            hif.cmd_rl_load   <= next_cmd.rl_load;
            hif.cmd_wl_load   <= next_cmd.wl_load;
            hif.cmd_wl_unload <= next_cmd.wl_unload;
            hif.cmd_rl_unload <= next_cmd.rl_unload;
            expose_active     <= (next_state == ST_EXPOSE);
            busy              <= (next_state != ST_IDLE) && (next_state != ST_FAULT);
            done              <= (next_state == ST_DONE);
            fault             <= (next_state == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_scanner_sequencer_fsm.sv
// Directed bench for scanner_sequencer_fsm with a latency-accurate handler
// model and per-cycle expected output timelines built from the lot recipe.
module tb_scanner_sequencer_fsm;
    import scanner_pkg::*;

    localparam int LOT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [LOT_W-1:0] lot_size;
    logic             expose_active;
    logic             busy;
    logic             done;
    logic             fault;
    logic [LOT_W-1:0] wafer_count;
    logic             wl_stub;

    int tests_run = 0;
    int failures  = 0;

    scanner_sequencer_fsm_if hif ();

    scanner_sequencer_fsm #(
        .EXPOSE_CYCLES (8),
        .TIMEOUT_CYCLES(16),
        .LOT_W         (LOT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .lot_size     (lot_size),
        .hif          (hif.master),
        .expose_active(expose_active),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .wafer_count  (wafer_count)
    );

    always #5 clk = ~clk;

    // Handler model: ready rises on the LATENCY-th edge that sees the command.
    int wl_cnt = 0;
    int rl_cnt = 0;
    always @(posedge clk) begin
        if (reset || !(hif.cmd_wl_load || hif.cmd_wl_unload)) begin
            wl_cnt       <= 0;
            hif.wl_ready <= 1'b0;
        end else begin
            wl_cnt       <= wl_cnt + 1;
            hif.wl_ready <= !wl_stub && (wl_cnt + 1 >= WL_LATENCY);
        end
        if (reset || !(hif.cmd_rl_load || hif.cmd_rl_unload)) begin
            rl_cnt       <= 0;
            hif.rl_ready <= 1'b0;
        end else begin
            rl_cnt       <= rl_cnt + 1;
            hif.rl_ready <= (rl_cnt + 1 >= RL_LATENCY);
        end
    end

    // Observed vector: {rl_load, wl_load, wl_unload, rl_unload, expose, busy, done, fault, wafer_count}
    logic [11:0] obs;
    assign obs = {hif.cmd_rl_load, hif.cmd_wl_load, hif.cmd_wl_unload, hif.cmd_rl_unload,
                  expose_active, busy, done, fault, wafer_count};

    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_RL_L = 4'b1000;
    localparam logic [3:0] C_WL_L = 4'b0100;
    localparam logic [3:0] C_WL_U = 4'b0010;
    localparam logic [3:0] C_RL_U = 4'b0001;

    logic [11:0] exp_q[$];

    function automatic logic [11:0] mk(input logic [3:0] cmd, input logic ex, input logic bz,
                                       input logic dn, input logic ft, input logic [3:0] wc);
        return {cmd, ex, bz, dn, ft, wc};
    endfunction

    task automatic push(input logic [11:0] v, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(v);
    endtask

    // Full expected timeline of a lot of n wafers, starting with the sample after the start edge.
    task automatic push_lot(input int n);
        push(mk(C_RL_L, 0, 1, 0, 0, 4'd0), 5);
        push(mk(C_NONE, 0, 1, 0, 0, 4'd0), 1);
        for (int w = 0; w < n; w++) begin
            push(mk(C_WL_L, 0, 1, 0, 0, 4'(w)), 6);
            push(mk(C_NONE, 0, 1, 0, 0, 4'(w)), 1);
            push(mk(C_NONE, 1, 1, 0, 0, 4'(w)), 8);
            push(mk(C_WL_U, 0, 1, 0, 0, 4'(w)), 6);
            push(mk(C_NONE, 0, 1, 0, 0, 4'(w + 1)), 1);
        end
        push(mk(C_RL_U, 0, 1, 0, 0, 4'(n)), 5);
        push(mk(C_NONE, 0, 1, 0, 0, 4'(n)), 1);
        push(mk(C_NONE, 0, 1, 1, 0, 4'(n)), 1);
        push(mk(C_NONE, 0, 0, 0, 0, 4'(n)), 2);
    endtask

    task automatic trim(input int keep);
        while (exp_q.size() > keep) void'(exp_q.pop_back());
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge, sample 1 ns later, then release single-cycle pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Walk the expected timeline; optionally inject abort/start/reset after a given sample.
    task automatic run_expect(input string name, input int abort_at, input int start_at,
                              input int reset_at);
        for (int i = 0; i < exp_q.size(); i++) begin
            tick();
            check($sformatf("%s[%0d]", name, i), 32'(obs), 32'(exp_q[i]));
            if (i == abort_at) abort = 1'b1;
            if (i == start_at) begin
                start    = 1'b1;
                lot_size = 4'd5;
            end
            if (i == reset_at) reset = 1'b1;
        end
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        lot_size = '0;
        wl_stub  = 1'b0;
        tick();
        tick();
        check("reset_outputs", 32'(obs), 32'h0);
        reset = 1'b0;

        // start with lot_size = 0 is ignored
        lot_size = 4'd0;
        start    = 1'b1;
        push(12'h000, 3);
        run_expect("lot0", -1, -1, -1);

        // single-wafer lot against the real handler
        lot_size = 4'd1;
        start    = 1'b1;
        push_lot(1);
        run_expect("lot1", -1, -1, -1);

        // three wafers, with a start pulse mid-lot that must be ignored
        lot_size = 4'd3;
        start    = 1'b1;
        push_lot(3);
        run_expect("lot3", -1, 15, -1);

        // full-width lot: wafer_count reaches 15 with no wrap
        lot_size = 4'd15;
        start    = 1'b1;
        push_lot(15);
        run_expect("lot15", -1, -1, -1);

        // abort in the 3rd EXPOSE cycle of wafer 2 (sample index 37)
        lot_size = 4'd3;
        start    = 1'b1;
        push_lot(3);
        trim(38);
        push(mk(C_NONE, 0, 0, 0, 0, 4'd1), 3);
        run_expect("abort", 37, -1, -1);

        // a fresh lot after abort runs normally
        lot_size = 4'd1;
        start    = 1'b1;
        push_lot(1);
        run_expect("post_abort", -1, -1, -1);

        // synchronous reset while cmd_wl_unload is high (wafer 2, sample 44)
        lot_size = 4'd2;
        start    = 1'b1;
        push_lot(2);
        trim(45);
        push(12'h000, 1);
        run_expect("reset_mid", -1, -1, 44);
        reset = 1'b0;
        push(12'h000, 2);
        run_expect("after_reset", -1, -1, -1);

        // wafer loader never answers: 16-cycle command then sticky FAULT
        wl_stub  = 1'b1;
        lot_size = 4'd1;
        start    = 1'b1;
        push(mk(C_RL_L, 0, 1, 0, 0, 4'd0), 5);
        push(mk(C_NONE, 0, 1, 0, 0, 4'd0), 1);
        push(mk(C_WL_L, 0, 1, 0, 0, 4'd0), 16);
        push(mk(C_NONE, 0, 0, 0, 1, 4'd0), 6);
        run_expect("timeout", 24, 22, -1);
        reset = 1'b1;
        tick();
        check("fault_reset", 32'(obs), 32'h0);
        reset   = 1'b0;
        wl_stub = 1'b0;
        tick();
        check("idle_after_fault", 32'(obs), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/scanner_sequencer_fsm.md
Name: scanner_sequencer_fsm

Overview:
Lot-level sequencer that initiates wafer-loader (WL) and reticle-loader (RL) commands toward the scanner handler.
- It holds each load/unload command as a level until the matching ready is seen, then drops it.
- Per lot: reticle load, then lot_size × (wafer load, exposure window, wafer unload), then reticle unload.
- Sits between the lot controller (start/abort/status) and the handler's cmd/ready interface.

Parameters:
EXPOSE_CYCLES, 8, cycles expose_active is held per wafer (≥1)
TIMEOUT_CYCLES, 16, max cycles a command may be held without ready before FAULT (≥2)
LOT_W, 4, width of lot_size and wafer_count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle lot start request
abort  in  1  abort current lot
lot_size  in  LOT_W  wafers in lot, sampled on accepted start
wl_ready  in  1  wafer loader done, from handler
rl_ready  in  1  reticle loader done, from handler
cmd_wl_load  out  1  wafer load command (level)
cmd_wl_unload  out  1  wafer unload command (level)
cmd_rl_load  out  1  reticle load command (level)
cmd_rl_unload  out  1  reticle unload command (level)
expose_active  out  1  exposure window
busy  out  1  high in every state except IDLE and FAULT
done  out  1  one-cycle pulse, lot complete
fault  out  1  sticky timeout flag
wafer_count  out  LOT_W  wafers completed in current lot

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. No asynchronous logic.
- Reset: state=IDLE; all cmd_*, expose_active, busy, done, fault = 0; wafer_count = 0. Reset mid-operation drops every command on the next edge.
- All outputs are registered and Moore-decoded from state. At most one cmd_* is high in any cycle.
- States: IDLE, RL_LOAD, WL_LOAD, EXPOSE, WL_UNLOAD, RL_UNLOAD, GAP, DONE, FAULT.
- IDLE: on start=1 with lot_size≠0:
  - latch lot_size, clear wafer_count;
  - go to RL_LOAD.
  - start with lot_size=0 is ignored.
  - start in any non-IDLE state is ignored.
- Command states (RL_LOAD, WL_LOAD, WL_UNLOAD, RL_UNLOAD): assert the matching cmd. When the matching ready is sampled high, go to GAP, where all cmds are low.
- GAP: exactly one cycle with all cmds low, so the handler timer clears before the next command. Successor depends on the command just completed:
  - after RL_LOAD → WL_LOAD;
  - after WL_LOAD → EXPOSE;
  - after WL_UNLOAD → wafer_count+1, then WL_LOAD if the new count < lot_size, else RL_UNLOAD;
  - after RL_UNLOAD → DONE.
- EXPOSE: expose_active=1 for exactly EXPOSE_CYCLES cycles, then WL_UNLOAD directly, with no gap (no cmd was active).
- DONE: done=1 for one cycle, then IDLE. wafer_count holds its value until the next accepted start.
- Ready-level rule: ready is qualified only in the state commanding that loader. A ready seen in GAP or other states is ignored.
- Timeout:
  - the watchdog clears on entry to each command state and counts cycles in it;
  - if the count reaches TIMEOUT_CYCLES without ready, go to FAULT;
  - FAULT: all cmds low, fault=1, busy=0;
  - exit only via reset.
  - Ready on the same cycle as the timeout wins (advance, no fault).
- Abort:
  - abort=1 in any busy state → IDLE next edge, all cmds low, no done pulse, wafer_count held.
  - Abort in IDLE, DONE or FAULT has no effect.
  - Abort has priority over ready/timeout.
- Handler timing (design reference): RL ready arrives on the 4th edge after cmd rise, WL on the 5th. So cmd_rl_* is high for 5 cycles and cmd_wl_* for 6 cycles per command.
- wafer_count never exceeds lot_size. lot_size = 2^LOT_W−1 must work without wrap.

Decomposition:
- Shared package scanner_pkg:
  - state encoding localparams (4-bit);
  - default EXPOSE_CYCLES and TIMEOUT_CYCLES;
  - handler latency constants WL_LATENCY=5 and RL_LATENCY=4 for benches.
- One sub-module, scanner_cmd_watchdog:
  - inputs: clear, run, ready;
  - output: timeout, when the count reaches TIMEOUT_CYCLES;
  - one instance shared across command states.

Test Plan:
- Reset, start lot_size=1, EXPOSE_CYCLES=8, against the real handler:
  - cmd_rl_load high 5 cycles; GAP; cmd_wl_load high 6 cycles; GAP;
  - expose_active high 8 cycles; cmd_wl_unload high 6 cycles; GAP;
  - cmd_rl_unload high 5 cycles; GAP; done pulse 1 cycle;
  - wafer_count=1; never two cmds high together.
- lot_size=3 → three WL_LOAD/EXPOSE/WL_UNLOAD passes, exactly one rl load and one rl unload, wafer_count steps 1,2,3, done once.
- Stubbed handler never raises wl_ready, TIMEOUT_CYCLES=16 → cmd_wl_load high 16 cycles, then all cmds 0, fault=1, busy=0; start ignored until reset.
- abort asserted during the 3rd cycle of EXPOSE of wafer 2 (lot_size=3) → next cycle IDLE, all outputs 0, wafer_count=1, no done; a subsequent start runs normally.
- start with lot_size=0 → stays IDLE, no command. start pulsed again mid-lot → ignored, sequence unchanged.
- Synchronous reset asserted while cmd_wl_unload is high → next edge all cmds 0, wafer_count=0, state IDLE.
